// File: rtl/jk_pattern_driver.sv
// jk_pattern_driver: drives j/k of an external JK flop so its q follows a loaded pattern, checking q one cycle behind.
module jk_pattern_driver #(
  parameter int LEN = 8,
  parameter bit DC_VAL = 1'b0,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN-1:0]          pattern,
  input  logic                    q_fb,
  output logic                    j,
  output logic                    k,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [$clog2(LEN)-1:0]  err_idx
);
  localparam int IW = $clog2(LEN);
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);
  localparam logic [IW-1:0] ONE = IW'(1);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [LEN-1:0] pat_r, pat_ord;
  logic [IW-1:0] idx;
  logic t, t_prev, mis, accept;
  // pattern is stored in drive order so the target is always pat_r[idx]
  always_comb begin
    pat_ord = pattern;
    for (int i = 0; i < LEN; i++) pat_ord[i] = MSB_FIRST ? pattern[LEN-1-i] : pattern[i];
  end
  always_comb begin
    t = pat_r[idx];
    mis = q_fb != t_prev;
    accept = start && !abort;
    j = 1'b0;
    k = 1'b0;
    state_nx = state;
    if (state == DRIVE) begin
      j = q_fb ? DC_VAL : t;
      k = q_fb ? ~t : DC_VAL;
    end
    case (state)
      IDLE:    state_nx = accept ? DRIVE : IDLE;
      DRIVE:   state_nx = abort ? IDLE : (idx != '0 && mis) ? DONE : (idx == LAST) ? CHECK : DRIVE;
      CHECK:   state_nx = abort ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state == DRIVE || state == CHECK;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat_r   <= '0;
      idx     <= '0;
      t_prev  <= 1'b0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && accept) begin
        pat_r   <= pat_ord;
        idx     <= '0;
        err     <= 1'b0;
        err_idx <= '0;
      end
      // t_prev holds the target whose effect on q is visible this cycle
      if (state == DRIVE && !abort) begin
        t_prev <= t;
        if (idx != '0 && mis) begin
          err     <= 1'b1;
          err_idx <= idx - ONE;
        end else if (idx != LAST) idx <= idx + ONE;
      end
      if (state == CHECK && !abort && mis) begin
        err     <= 1'b1;
        err_idx <= LAST;
      end
    end
  end
endmodule

// File: tb/tb_jk_pattern_driver.sv
// tb_jk_pattern_driver: three driver variants (plain, DC_VAL=1, MSB_FIRST=1) each driving a behavioural JK flop.
module tb_jk_pattern_driver;
  localparam bit [2:0] DCV = 3'b010;
  localparam bit [2:0] MSBV = 3'b100;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, stuck = 1'b0;
  logic [7:0] pat = '0;
  logic [2:0] jv, kv, bv, dv, ev;
  logic [2:0] iv [3];
  logic qf [3];
  int total = 0, bad = 0, cyc = 0;
  bit active = 1'b0;
  bit ej [3][16], ek [3][16], eb [3][16], ed [3][16], ee [3][16];
  int elen [3];
  logic [2:0] eidx [3];
  bit mq [3] = '{1'b0, 1'b0, 1'b0};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    jk_pattern_driver #(.LEN(8), .DC_VAL(DCV[g]), .MSB_FIRST(MSBV[g])) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pat), .q_fb(qf[g]),
      .j(jv[g]), .k(kv[g]), .busy(bv[g]), .done(dv[g]), .err(ev[g]), .err_idx(iv[g])
    );
  end
  always @(posedge clk or negedge rst)
    for (int u = 0; u < 3; u++)
      if (!rst) qf[u] <= 1'b0;
      else if (stuck) qf[u] <= 1'b1;
      else qf[u] <= (jv[u] && kv[u]) ? ~qf[u] : jv[u] ? 1'b1 : kv[u] ? 1'b0 : qf[u];
  task automatic chk(input string nm, input int u, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d cyc=%0d got=%0h want=%0h", nm, u, cyc, act, exp);
    end
  endtask
  // expected per-cycle outputs from the excitation table and the flop's characteristic equation
  task automatic build(input int u, input logic [7:0] p, input bit s);
    bit q, t, tp, jj, kk, e;
    int last;
    logic [2:0] ei;
    q = s ? 1'b1 : mq[u];
    tp = 1'b0; e = 1'b0; last = 0; ei = '0;
    for (int c = 0; c < 16; c++) begin
      ej[u][c] = 0; ek[u][c] = 0; eb[u][c] = 0; ed[u][c] = 0; ee[u][c] = 0;
    end
    for (int i = 0; i < 8 && !e; i++) begin
      t = MSBV[u] ? p[7-i] : p[i];
      case ({q, t})
        2'b00:   {jj, kk} = {1'b0, DCV[u]};
        2'b01:   {jj, kk} = {1'b1, DCV[u]};
        2'b10:   {jj, kk} = {DCV[u], 1'b1};
        default: {jj, kk} = {DCV[u], 1'b0};
      endcase
      ej[u][i+1] = jj; ek[u][i+1] = kk; eb[u][i+1] = 1'b1;
      if (i > 0 && q != tp) begin e = 1'b1; ei = 3'(i - 1); end
      tp = t;
      q = s ? 1'b1 : (jj && kk) ? !q : jj ? 1'b1 : kk ? 1'b0 : q;
      last = i + 1;
    end
    if (!e) begin
      last = 9;
      eb[u][9] = 1'b1;
      if (q != tp) begin e = 1'b1; ei = 3'd7; end
    end
    ed[u][last+1] = 1'b1;
    ee[u][last+1] = e;
    ee[u][last+2] = e;
    elen[u] = last + 2;
    eidx[u] = ei;
    mq[u] = q;
  endtask
  always @(negedge clk)
    if (active)
      for (int u = 0; u < 3; u++)
        if (cyc <= elen[u]) begin
          chk("j", u, jv[u], ej[u][cyc]);
          chk("k", u, kv[u], ek[u][cyc]);
          chk("busy", u, bv[u], eb[u][cyc]);
          chk("done", u, dv[u], ed[u][cyc]);
          chk("err", u, ev[u], ee[u][cyc]);
          if (ee[u][cyc]) chk("err_idx", u, iv[u], eidx[u]);
        end
  task automatic run(input logic [7:0] p, input bit s);
    int n;
    n = 0;
    for (int u = 0; u < 3; u++) begin
      build(u, p, s);
      if (elen[u] > n) n = elen[u];
    end
    pat = p;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pat = ~p;
    cyc = 1;
    active = 1'b1;
    repeat (n - 1) begin
      @(posedge clk);
      #1 cyc++;
    end
    @(posedge clk);
    #1 active = 1'b0;
  endtask
  task automatic rst_pulse();
    rst = 1'b0;
    #1 rst = 1'b1;
    for (int u = 0; u < 3; u++) mq[u] = 1'b0;
  endtask
  initial begin
    logic [1:0] jk0 [8];
    logic [1:0] jk1 [8];
    jk0 = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    jk1 = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("rst_j", u, jv[u], 0); chk("rst_k", u, kv[u], 0); chk("rst_busy", u, bv[u], 0);
      chk("rst_done", u, dv[u], 0); chk("rst_err", u, ev[u], 0); chk("rst_err_idx", u, iv[u], 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    run(8'hB2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("pin_jk_dc0", 0, {ej[0][i+1], ek[0][i+1]}, jk0[i]);
      chk("pin_jk_dc1", 1, {ej[1][i+1], ek[1][i+1]}, jk1[i]);
    end
    chk("pin_done_at10", 0, ed[0][10], 1);
    chk("q_end_b2", 0, qf[0], 1);
    chk("q_end_b2", 1, qf[1], 1);
    stuck = 1'b1;
    @(posedge clk);
    #1;
    run(8'h00, 1'b1);
    stuck = 1'b0;
    chk("pin_done_at3", 0, ed[0][3], 1);
    chk("stuck_err", 0, ev[0], 1);
    chk("stuck_err_idx", 0, iv[0], 0);
    chk("stuck_jk_after", 0, {jv[0], kv[0]}, 0);
    rst_pulse();
    @(posedge clk);
    #1;
    run(8'h80, 1'b0);
    chk("pin_msb_first_jk", 2, {ej[2][1], ek[2][1]}, 2'b10);
    chk("msb_q_end", 2, qf[2], 0);
    chk("msb_err", 2, ev[2], 0);
    pat = 8'h5A;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("mid_busy", 0, bv[0], 1);
    rst = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("mid_rst_jk", u, {jv[u], kv[u]}, 0);
      chk("mid_rst_busy", u, bv[u], 0);
      chk("mid_rst_done", u, dv[u], 0);
    end
    #1 rst_pulse();
    @(posedge clk);
    #1;
    run(8'hFF, 1'b0);
    chk("ff_err", 0, ev[0], 0);
    pat = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b1;
    chk("pre_abort_busy", 0, bv[0], 1);
    @(posedge clk);
    #1 abort = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("abort_busy", 0, bv[0], 0);
      chk("abort_done", 0, dv[0], 0);
      @(posedge clk);
      #1;
    end
    chk("abort_err", 0, ev[0], 0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_wins", 0, bv[0], 0);
    @(posedge clk);
    #1 chk("idle_abort_wins2", 0, bv[0], 0);
    rst_pulse();
    @(posedge clk);
    #1;
    run(8'h3C, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
